// File: rtl/br_flush_ctl.sv
// Branch-mispredict flush controller: picks the oldest mispredict by ROB id and sequences one flush at a time.
// Optional BR_FLUSH_STATS_EN adds saturating flush/replacement statistics counters as output ports.
module br_flush_ctl #(
    parameter int NUM_SRC   = 2,
    parameter int ROBID_W   = 6,
    parameter int PC_W      = 64,
    parameter int USEQ_W    = 12,
    parameter int DRAIN_CYC = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC-1:0]          mp_valid,
    input  logic [NUM_SRC*ROBID_W-1:0]  mp_robid,
    input  logic [NUM_SRC*PC_W-1:0]     mp_restore_pc,
    input  logic [NUM_SRC*USEQ_W-1:0]   mp_restore_useq,
    input  logic [NUM_SRC-1:0]          mp_ucbr,
    output logic                        flush_req,
    input  logic                        flush_ack,
    output logic [ROBID_W-1:0]          flush_robid,
    output logic [PC_W-1:0]             flush_pc,
    output logic [USEQ_W-1:0]           flush_useq,
    output logic                        flush_ucbr,
`ifdef BR_FLUSH_STATS_EN
    output logic [31:0]                 stat_flushes,
    output logic [31:0]                 stat_ucbr_flushes,
    output logic [31:0]                 stat_replaced,
`endif
    output logic                        busy
);

    localparam int CNT_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   drain_cnt;
    logic [ROBID_W-1:0] fence;

    logic               win_valid;
    logic [ROBID_W-1:0] win_robid;
    logic [PC_W-1:0]    win_pc;
    logic [USEQ_W-1:0]  win_useq;
    logic               win_ucbr;

    logic               win_older_held;
    logic               win_older_fence;
    logic               ack_fire;
    logic               capture;

    // Wrap-aware age compare: differing wrap bits invert the sense of the low-bit compare.
    function automatic logic is_older(input logic [ROBID_W-1:0] a,
                                      input logic [ROBID_W-1:0] b);
        logic [ROBID_W-2:0] a_lo;
        logic [ROBID_W-2:0] b_lo;
        a_lo = a[ROBID_W-2:0];
        b_lo = b[ROBID_W-2:0];
        if (a[ROBID_W-1] ^ b[ROBID_W-1])
            return a_lo > b_lo;
        else
            return a_lo < b_lo;
    endfunction

    // Ascending scan with strict compare so equal ROB ids resolve to the lower source index.
    always_comb begin
        win_valid = 1'b0;
        win_robid = '0;
        win_pc    = '0;
        win_useq  = '0;
        win_ucbr  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (mp_valid[i] &&
                (!win_valid || is_older(mp_robid[i*ROBID_W +: ROBID_W], win_robid))) begin
                win_valid = 1'b1;
                win_robid = mp_robid[i*ROBID_W +: ROBID_W];
                win_pc    = mp_restore_pc[i*PC_W +: PC_W];
                win_useq  = mp_restore_useq[i*USEQ_W +: USEQ_W];
                win_ucbr  = mp_ucbr[i];
            end
        end
    end

    always_comb begin
        win_older_held  = win_valid && is_older(win_robid, flush_robid);
        win_older_fence = win_valid && is_older(win_robid, fence);
        ack_fire        = (state == HOLD) && flush_req && flush_ack;
        capture         = 1'b0;
        case (state)
            IDLE:    capture = win_valid;
            HOLD:    capture = win_older_held;
            DRAIN:   capture = win_older_fence;
            default: capture = 1'b0;
        endcase
    end

    // Flush sequencer; the payload registers only move on capture so outputs hold while idle/draining.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            drain_cnt   <= '0;
            fence       <= '0;
            flush_req   <= 1'b0;
            flush_robid <= '0;
            flush_pc    <= '0;
            flush_useq  <= '0;
            flush_ucbr  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        flush_req <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (ack_fire) begin
                        fence <= flush_robid;
                        if (!win_older_held) begin
                            flush_req <= 1'b0;
                            drain_cnt <= CNT_W'(DRAIN_CYC);
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (win_older_fence) begin
                        flush_req <= 1'b1;
                        state     <= HOLD;
                    end else if (drain_cnt <= CNT_W'(1)) begin
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    flush_req <= 1'b0;
                end
            endcase

            if (capture) begin
                flush_robid <= win_robid;
                flush_pc    <= win_pc;
                flush_useq  <= win_useq;
                flush_ucbr  <= win_ucbr;
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef BR_FLUSH_STATS_EN
    // Replacement counts only the no-ack case; an older winner arriving with an ack is a fresh flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_flushes      <= '0;
            stat_ucbr_flushes <= '0;
            stat_replaced     <= '0;
        end else begin
            if (ack_fire && (stat_flushes != '1))
                stat_flushes <= stat_flushes + 32'd1;
            if (ack_fire && flush_ucbr && (stat_ucbr_flushes != '1))
                stat_ucbr_flushes <= stat_ucbr_flushes + 32'd1;
            if ((state == HOLD) && !ack_fire && win_older_held && (stat_replaced != '1))
                stat_replaced <= stat_replaced + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_br_flush_ctl.sv
// Directed testbench for br_flush_ctl; stats checks are compiled in when BR_FLUSH_STATS_EN is defined.
module tb_br_flush_ctl;

    localparam int NUM_SRC = 2;
    localparam int ROBID_W = 6;
    localparam int PC_W    = 64;
    localparam int USEQ_W  = 12;

    logic                       clk;
    logic                       reset;
    logic [NUM_SRC-1:0]         mp_valid;
    logic [NUM_SRC*ROBID_W-1:0] mp_robid;
    logic [NUM_SRC*PC_W-1:0]    mp_restore_pc;
    logic [NUM_SRC*USEQ_W-1:0]  mp_restore_useq;
    logic [NUM_SRC-1:0]         mp_ucbr;
    logic                       flush_req;
    logic                       flush_ack;
    logic [ROBID_W-1:0]         flush_robid;
    logic [PC_W-1:0]            flush_pc;
    logic [USEQ_W-1:0]          flush_useq;
    logic                       flush_ucbr;
    logic                       busy;
`ifdef BR_FLUSH_STATS_EN
    logic [31:0]                stat_flushes;
    logic [31:0]                stat_ucbr_flushes;
    logic [31:0]                stat_replaced;
`endif

    int checks = 0;
    int errors = 0;

    br_flush_ctl #(
        .NUM_SRC(NUM_SRC), .ROBID_W(ROBID_W), .PC_W(PC_W), .USEQ_W(USEQ_W), .DRAIN_CYC(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mp_valid(mp_valid),
        .mp_robid(mp_robid),
        .mp_restore_pc(mp_restore_pc),
        .mp_restore_useq(mp_restore_useq),
        .mp_ucbr(mp_ucbr),
        .flush_req(flush_req),
        .flush_ack(flush_ack),
        .flush_robid(flush_robid),
        .flush_pc(flush_pc),
        .flush_useq(flush_useq),
        .flush_ucbr(flush_ucbr),
`ifdef BR_FLUSH_STATS_EN
        .stat_flushes(stat_flushes),
        .stat_ucbr_flushes(stat_ucbr_flushes),
        .stat_replaced(stat_replaced),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int idx, input logic [ROBID_W-1:0] robid,
                           input logic [PC_W-1:0] pc, input logic [USEQ_W-1:0] useq,
                           input logic ucbr);
        mp_valid[idx]                       = 1'b1;
        mp_robid[idx*ROBID_W +: ROBID_W]    = robid;
        mp_restore_pc[idx*PC_W +: PC_W]     = pc;
        mp_restore_useq[idx*USEQ_W +: USEQ_W] = useq;
        mp_ucbr[idx]                        = ucbr;
    endtask

    task automatic clear_src();
        mp_valid        = '0;
        mp_robid        = '0;
        mp_restore_pc   = '0;
        mp_restore_useq = '0;
        mp_ucbr         = '0;
    endtask

    // Ack the held packet and let the drain window expire back to IDLE.
    task automatic ack_and_drain();
        flush_ack = 1'b1;
        step();
        flush_ack = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_src();
        flush_ack = 1'b0;
        repeat (2) step();
        checks++;
        if ({flush_req, busy, flush_ucbr} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got req/busy/ucbr=%b expected 000", {flush_req, busy, flush_ucbr});
        end
        checks++;
        if ({flush_robid, flush_pc, flush_useq} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_payload: got robid=%0d pc=%0h useq=%0h expected all 0",
                     flush_robid, flush_pc, flush_useq);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        set_src(0, 6'd5, 64'h1000, 12'h012, 1'b0);
        step();
        clear_src();
        checks++;
        if (flush_req !== 1'b1 || flush_robid !== 6'd5 || flush_pc !== 64'h1000 || flush_useq !== 12'h012) begin
            errors++;
            $display("[TB] FAIL single_capture: got req=%0b robid=%0d pc=%0h useq=%0h expected 1/5/1000/12",
                     flush_req, flush_robid, flush_pc, flush_useq);
        end
        flush_ack = 1'b1;
        step();
        flush_ack = 1'b0;
        checks++;
        if (flush_req !== 1'b0 || flush_robid !== 6'd5) begin
            errors++;
            $display("[TB] FAIL single_ack: got req=%0b robid=%0d expected 0/5", flush_req, flush_robid);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== (i < 3)) begin
                errors++;
                $display("[TB] FAIL single_busy%0d: got %0b expected %0b", i, busy, (i < 3));
            end
            step();
        end
    endtask

    task automatic test_simultaneous();
        set_src(0, 6'd9, 64'hA0, 12'h0AA, 1'b0);
        set_src(1, 6'd4, 64'hB0, 12'h033, 1'b1);
        step();
        clear_src();
        checks++;
        if (flush_robid !== 6'd4 || flush_pc !== 64'hB0 || flush_useq !== 12'h033 || flush_ucbr !== 1'b1) begin
            errors++;
            $display("[TB] FAIL simul_winner: got robid=%0d pc=%0h useq=%0h ucbr=%0b expected 4/b0/33/1",
                     flush_robid, flush_pc, flush_useq, flush_ucbr);
        end
        ack_and_drain();
    endtask

    task automatic test_equal_robid();
        set_src(0, 6'd7, 64'hC0, 12'h001, 1'b0);
        set_src(1, 6'd7, 64'hD0, 12'h002, 1'b1);
        step();
        clear_src();
        checks++;
        if (flush_pc !== 64'hC0 || flush_ucbr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL equal_tie: got pc=%0h ucbr=%0b expected c0/0", flush_pc, flush_ucbr);
        end
        ack_and_drain();
    endtask

    task automatic test_wrap();
        set_src(0, 6'b100010, 64'h200, 12'h000, 1'b0);
        set_src(1, 6'b011110, 64'h300, 12'h000, 1'b0);
        step();
        clear_src();
        checks++;
        if (flush_robid !== 6'b011110 || flush_pc !== 64'h300) begin
            errors++;
            $display("[TB] FAIL wrap_winner: got robid=%b pc=%0h expected 011110/300", flush_robid, flush_pc);
        end
        ack_and_drain();
    endtask

    task automatic test_replace();
`ifdef BR_FLUSH_STATS_EN
        logic [31:0] rep_before;
        rep_before = stat_replaced;
`endif
        set_src(0, 6'd10, 64'h100, 12'h010, 1'b0);
        step();
        clear_src();
        set_src(1, 6'd7, 64'h700, 12'h070, 1'b0);
        step();
        clear_src();
        checks++;
        if (flush_req !== 1'b1 || flush_robid !== 6'd7 || flush_pc !== 64'h700) begin
            errors++;
            $display("[TB] FAIL replace_older: got req=%0b robid=%0d pc=%0h expected 1/7/700",
                     flush_req, flush_robid, flush_pc);
        end
        set_src(0, 6'd12, 64'hC00, 12'h0C0, 1'b0);
        step();
        set_src(0, 6'd7, 64'hEEE, 12'h0EE, 1'b0);
        step();
        clear_src();
        checks++;
        if (flush_robid !== 6'd7 || flush_pc !== 64'h700) begin
            errors++;
            $display("[TB] FAIL replace_younger_drop: got robid=%0d pc=%0h expected 7/700", flush_robid, flush_pc);
        end
        flush_ack = 1'b1;
        step();
        flush_ack = 1'b0;
`ifdef BR_FLUSH_STATS_EN
        checks++;
        if (stat_replaced !== rep_before + 32'd1) begin
            errors++;
            $display("[TB] FAIL replace_stat: got %0d expected %0d", stat_replaced, rep_before + 32'd1);
        end
`endif
        repeat (4) step();
    endtask

    task automatic test_drain_fence();
        set_src(0, 6'd8, 64'h800, 12'h080, 1'b0);
        step();
        clear_src();
        flush_ack = 1'b1;
        step();
        flush_ack = 1'b0;
        set_src(0, 6'd11, 64'hB00, 12'h0B0, 1'b0);
        step();
        clear_src();
        checks++;
        if (flush_req !== 1'b0 || busy !== 1'b1 || flush_robid !== 6'd8) begin
            errors++;
            $display("[TB] FAIL fence_drop: got req=%0b busy=%0b robid=%0d expected 0/1/8",
                     flush_req, busy, flush_robid);
        end
        set_src(1, 6'd3, 64'h300, 12'h030, 1'b1);
        step();
        clear_src();
        checks++;
        if (flush_req !== 1'b1 || flush_robid !== 6'd3 || flush_pc !== 64'h300) begin
            errors++;
            $display("[TB] FAIL fence_older_capture: got req=%0b robid=%0d pc=%0h expected 1/3/300",
                     flush_req, flush_robid, flush_pc);
        end
        ack_and_drain();
    endtask

    task automatic test_ack_with_older();
        set_src(0, 6'd20, 64'h2000, 12'h200, 1'b0);
        step();
        clear_src();
        set_src(1, 6'd15, 64'h1500, 12'h150, 1'b0);
        flush_ack = 1'b1;
        step();
        flush_ack = 1'b0;
        clear_src();
        checks++;
        if (flush_req !== 1'b1 || busy !== 1'b1 || flush_robid !== 6'd15 || flush_pc !== 64'h1500) begin
            errors++;
            $display("[TB] FAIL ack_older: got req=%0b busy=%0b robid=%0d pc=%0h expected 1/1/15/1500",
                     flush_req, busy, flush_robid, flush_pc);
        end
        ack_and_drain();
        checks++;
        if (busy !== 1'b0 || flush_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ack_older_idle: got busy=%0b req=%0b expected 0/0", busy, flush_req);
        end
    endtask

    task automatic test_stray_ack();
        flush_ack = 1'b1;
        repeat (2) step();
        flush_ack = 1'b0;
        checks++;
        if (flush_req !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL stray_ack: got req=%0b busy=%0b expected 0/0", flush_req, busy);
        end
    endtask

    task automatic test_reset_mid_hold();
        set_src(0, 6'd5, 64'h5555, 12'h555, 1'b1);
        step();
        clear_src();
        checks++;
        if (flush_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midhold_setup: got req=%0b expected 1", flush_req);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (flush_req !== 1'b0 || busy !== 1'b0 || flush_robid !== '0 || flush_pc !== '0) begin
            errors++;
            $display("[TB] FAIL midhold_reset: got req=%0b busy=%0b robid=%0d pc=%0h expected 0/0/0/0",
                     flush_req, busy, flush_robid, flush_pc);
        end
`ifdef BR_FLUSH_STATS_EN
        checks++;
        if (stat_flushes !== '0 || stat_ucbr_flushes !== '0 || stat_replaced !== '0) begin
            errors++;
            $display("[TB] FAIL midhold_stats: got %0d/%0d/%0d expected 0/0/0",
                     stat_flushes, stat_ucbr_flushes, stat_replaced);
        end
`endif
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_equal_robid();
        test_wrap();
        test_replace();
        test_drain_fence();
        test_ack_with_older();
        test_stray_ack();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
